// File: rtl/mem_access_unit_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : mem_access_unit_pkg                                         |
// | Brief   : Bus widths, FSM state encoding, access-size masks and the   |
// |           request context record shared by the memory access unit.    |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
package mem_access_unit_pkg;

  // Bus widths
  localparam int DATA_BUS_W     = 32;
  localparam int ADDR_BUS_W     = 32;
  localparam int MEM_SEL_BUS_W  = 4;
  localparam int REG_ADDR_BUS_W = 5;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // Size selector codes as presented on mem_sel_in
  localparam logic [3:0] SEL_BYTE = 4'b0001;
  localparam logic [3:0] SEL_HALF = 4'b0011;
  localparam logic [3:0] SEL_WORD = 4'b1111;

  // Internal compact size code
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Everything about the in-flight access that DONE still needs
  typedef struct packed {
    logic       is_write;
    logic       sign;
    logic [1:0] size;
    logic [1:0] offset;
  } req_ctx_t;

  // Unknown selector codes fall back to a full word
  function automatic logic [1:0] decode_size(input logic [3:0] sel);
    case (sel)
      SEL_BYTE: return SZ_BYTE;
      SEL_HALF: return SZ_HALF;
      default:  return SZ_WORD;
    endcase
  endfunction

  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE: return SEL_BYTE;
      SZ_HALF: return SEL_HALF;
      default: return SEL_WORD;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_load_align.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : load_align                                                  |
// | Brief   : Combinational load data alignment: shifts the captured RAM  |
// |           word down to the addressed byte lane, then zero- or sign-   |
// |           extends byte/halfword loads.                                |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
module load_align
  import mem_access_unit_pkg::*;
(
  input  logic [DATA_BUS_W-1:0] i_raw,
  input  logic [1:0]            i_offset,
  input  logic [1:0]            i_size,
  input  logic                  i_sign,
  output logic [DATA_BUS_W-1:0] o_data
);

  logic [DATA_BUS_W-1:0] w_shifted;

  // Lane shift followed by width-dependent extension
  always_comb begin
    w_shifted = i_raw >> {i_offset, 3'b000};
    case (i_size)
      SZ_BYTE: o_data = {{24{i_sign & w_shifted[7]}},  w_shifted[7:0]};
      SZ_HALF: o_data = {{16{i_sign & w_shifted[15]}}, w_shifted[15:0]};
      default: o_data = w_shifted;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : mem_access_unit                                             |
// | Brief   : MEM pipeline stage. Passes ALU results through, or runs a   |
// |           single data-RAM transaction (IDLE -> ACCESS -> DONE) while  |
// |           stalling the earlier stages.                                |
// | Config  : `define MEM_MISALIGN_CHECK_EN adds misalign_exc and drops   |
// |           misaligned halfword/word accesses instead of issuing them.  |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  // From EX/MEM
  input  logic                      mem_read_flag_in,
  input  logic                      mem_write_flag_in,
  input  logic                      mem_sign_flag_in,
  input  logic [MEM_SEL_BUS_W-1:0]  mem_sel_in,
  input  logic [DATA_BUS_W-1:0]     mem_write_data_in,
  input  logic [DATA_BUS_W-1:0]     result_in,
  input  logic                      reg_write_en_in,
  input  logic [REG_ADDR_BUS_W-1:0] reg_write_addr_in,
  input  logic [ADDR_BUS_W-1:0]     current_pc_addr_in,
  // To MEM/WB
  output logic [DATA_BUS_W-1:0]     result_out,
  output logic                      reg_write_en_out,
  output logic [REG_ADDR_BUS_W-1:0] reg_write_addr_out,
  output logic [ADDR_BUS_W-1:0]     current_pc_addr_out,
  // Data RAM
  output logic                      ram_en,
  output logic                      ram_write_en,
  output logic [ADDR_BUS_W-1:0]     ram_addr,
  output logic [MEM_SEL_BUS_W-1:0]  ram_sel,
  output logic [DATA_BUS_W-1:0]     ram_write_data,
  input  logic [DATA_BUS_W-1:0]     ram_read_data,
  input  logic                      ram_ready,
`ifdef MEM_MISALIGN_CHECK_EN
  output logic                      misalign_exc,
`endif
  output logic                      stall_request
);

  logic [1:0]            r_state;
  logic [1:0]            w_next_state;
  logic                  r_ram_en;
  logic                  r_ram_we;
  logic [ADDR_BUS_W-1:0] r_ram_addr;
  logic [3:0]            r_ram_sel;
  logic [DATA_BUS_W-1:0] r_ram_wdata;
  logic [DATA_BUS_W-1:0] r_load;
  req_ctx_t              r_ctx;

  logic                  w_mem_op;
  logic [1:0]            w_size;
  logic [3:0]            w_mask;
  logic                  w_misalign;
  logic                  w_start;
  logic [DATA_BUS_W-1:0] w_load_data;

  assign w_mem_op = mem_read_flag_in | mem_write_flag_in;
  assign w_size   = decode_size(mem_sel_in);
  assign w_mask   = size_mask(w_size);

`ifdef MEM_MISALIGN_CHECK_EN
  assign w_misalign = w_mem_op &&
                      (((w_size == SZ_HALF) && result_in[0]) ||
                       ((w_size == SZ_WORD) && (result_in[1:0] != 2'b00)));
  assign misalign_exc = (r_state == ST_IDLE) && w_misalign;
`else
  // Misaligned accesses are issued anyway; the shifted strobes simply
  // lose the lanes that fall off the top of the word.
  assign w_misalign = 1'b0;
`endif

  assign w_start = (r_state == ST_IDLE) && w_mem_op && !w_misalign;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state: one request per IDLE visit, DONE always returns to IDLE
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (w_start)   w_next_state = ST_ACCESS;
      ST_ACCESS: if (ram_ready) w_next_state = ST_DONE;
      ST_DONE:                  w_next_state = ST_IDLE;
      default:                  w_next_state = ST_IDLE;
    endcase
  end

  // RAM request registers: loaded on entry to ACCESS, enables dropped on ready
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_sel   <= '0;
      r_ram_wdata <= '0;
      r_load      <= '0;
      r_ctx       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_ram_en    <= 1'b1;
            r_ram_we    <= mem_write_flag_in;
            r_ram_addr  <= {result_in[31:2], 2'b00};
            r_ram_sel   <= w_mask << result_in[1:0];
            r_ram_wdata <= mem_write_data_in << {result_in[1:0], 3'b000};
            r_ctx       <= '{is_write: mem_write_flag_in,
                             sign:     mem_sign_flag_in,
                             size:     w_size,
                             offset:   result_in[1:0]};
          end
        end
        ST_ACCESS: begin
          if (ram_ready) begin
            r_load   <= ram_read_data;
            r_ram_en <= 1'b0;
            r_ram_we <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  load_align u_load_align (
    .i_raw    (r_load),
    .i_offset (r_ctx.offset),
    .i_size   (r_ctx.size),
    .i_sign   (r_ctx.sign),
    .o_data   (w_load_data)
  );

  // Stage outputs: pass-through by default, held off while an access runs
  always_comb begin
    stall_request    = 1'b0;
    reg_write_en_out = reg_write_en_in;
    result_out       = result_in;
    case (r_state)
      ST_IDLE: begin
        if (w_mem_op) begin
          reg_write_en_out = 1'b0;
          stall_request    = !w_misalign;
        end
      end
      ST_ACCESS: begin
        reg_write_en_out = 1'b0;
        stall_request    = 1'b1;
      end
      ST_DONE: begin
        if (!r_ctx.is_write) result_out = w_load_data;
      end
      default: ;
    endcase
  end

  assign reg_write_addr_out  = reg_write_addr_in;
  assign current_pc_addr_out = current_pc_addr_in;
  assign ram_en              = r_ram_en;
  assign ram_write_en        = r_ram_we;
  assign ram_addr            = r_ram_addr;
  assign ram_sel             = r_ram_sel;
  assign ram_write_data      = r_ram_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : tb_mem_access_unit                                          |
// | Brief   : Scoreboard bench for mem_access_unit: a driver issues       |
// |           directed instructions, a RAM model answers requests, and a  |
// |           monitor checks every retiring instruction.                  |
// | Config  : honours `define MEM_MISALIGN_CHECK_EN                       |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_flag_in, mem_write_flag_in, mem_sign_flag_in;
  logic [3:0]  mem_sel_in;
  logic [31:0] mem_write_data_in, result_in;
  logic        reg_write_en_in;
  logic [4:0]  reg_write_addr_in;
  logic [31:0] current_pc_addr_in;
  logic [31:0] result_out;
  logic        reg_write_en_out;
  logic [4:0]  reg_write_addr_out;
  logic [31:0] current_pc_addr_out;
  logic        ram_en, ram_write_en;
  logic [31:0] ram_addr;
  logic [3:0]  ram_sel;
  logic [31:0] ram_write_data;
  logic [31:0] ram_read_data;
  logic        ram_ready;
  logic        stall_request;
`ifdef MEM_MISALIGN_CHECK_EN
  logic        misalign_exc;
`endif

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk                 (clk),
    .rst                 (rst),
    .mem_read_flag_in    (mem_read_flag_in),
    .mem_write_flag_in   (mem_write_flag_in),
    .mem_sign_flag_in    (mem_sign_flag_in),
    .mem_sel_in          (mem_sel_in),
    .mem_write_data_in   (mem_write_data_in),
    .result_in           (result_in),
    .reg_write_en_in     (reg_write_en_in),
    .reg_write_addr_in   (reg_write_addr_in),
    .current_pc_addr_in  (current_pc_addr_in),
    .result_out          (result_out),
    .reg_write_en_out    (reg_write_en_out),
    .reg_write_addr_out  (reg_write_addr_out),
    .current_pc_addr_out (current_pc_addr_out),
    .ram_en              (ram_en),
    .ram_write_en        (ram_write_en),
    .ram_addr            (ram_addr),
    .ram_sel             (ram_sel),
    .ram_write_data      (ram_write_data),
    .ram_read_data       (ram_read_data),
    .ram_ready           (ram_ready),
`ifdef MEM_MISALIGN_CHECK_EN
    .misalign_exc        (misalign_exc),
`endif
    .stall_request       (stall_request)
  );

  typedef struct {
    logic [31:0] result;
    logic        rwe;
    logic [4:0]  waddr;
    logic [31:0] pc;
    int          stall;
    logic        exc;
  } ret_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
  } ramx_t;

  ret_t  ret_q[$];
  ramx_t ram_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 1'b0;
  bit    ram_auto = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp_ret(input logic [31:0] result, input logic rwe, input logic [4:0] waddr,
                         input logic [31:0] pc, input int stall, input logic exc);
    ret_t e;
    e.result = result; e.rwe = rwe; e.waddr = waddr; e.pc = pc; e.stall = stall; e.exc = exc;
    ret_q.push_back(e);
  endtask

  task automatic exp_ram(input logic [31:0] addr, input logic [3:0] sel, input logic we,
                         input logic [31:0] wdata, input logic [31:0] rdata, input int lat);
    ramx_t r;
    r.addr = addr; r.sel = sel; r.we = we; r.wdata = wdata; r.rdata = rdata; r.lat = lat;
    ram_q.push_back(r);
  endtask

  // Drive one instruction and hold it until the stage stops stalling
  task automatic issue(input logic rd, input logic wr, input logic sg, input logic [3:0] sel,
                       input logic [31:0] wdata, input logic [31:0] res, input logic rwe,
                       input logic [4:0] waddr, input logic [31:0] pc);
    bit done;
    mem_read_flag_in   = rd;
    mem_write_flag_in  = wr;
    mem_sign_flag_in   = sg;
    mem_sel_in         = sel;
    mem_write_data_in  = wdata;
    result_in          = res;
    reg_write_en_in    = rwe;
    reg_write_addr_in  = waddr;
    current_pc_addr_in = pc;
    mon_en = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!stall_request) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got stall_request=1 for 20 cycles expected retire (res=%h)", res);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every retiring instruction against the scoreboard
  initial begin
    int   stall_cnt;
    ret_t e;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (stall_request) begin
          stall_cnt++;
          chk("rwe_during_stall", {31'd0, reg_write_en_out}, 32'd0);
        end else begin
          if (ret_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_retire: got result_out=%h expected no retire", result_out);
          end else begin
            e = ret_q.pop_front();
            chk("result_out", result_out, e.result);
            chk("reg_write_en_out", {31'd0, reg_write_en_out}, {31'd0, e.rwe});
            chk("reg_write_addr_out", {27'd0, reg_write_addr_out}, {27'd0, e.waddr});
            chk("current_pc_addr_out", current_pc_addr_out, e.pc);
            chk("stall_cycles", stall_cnt, e.stall);
`ifdef MEM_MISALIGN_CHECK_EN
            chk("misalign_exc", {31'd0, misalign_exc}, {31'd0, e.exc});
`endif
          end
          stall_cnt = 0;
        end
      end else begin
        stall_cnt = 0;
      end
    end
  end

  // RAM model: checks request fields every ACCESS cycle, answers after lat cycles
  initial begin
    ramx_t cur;
    bit    active;
    int    cnt;
    active = 1'b0;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (ram_auto) begin
        if (ram_ready) begin
          ram_ready     = 1'b0;
          ram_read_data = '0;
        end else if (ram_en) begin
          if (!active) begin
            if (ram_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_ram_access: got ram_en=1 addr=%h expected no access", ram_addr);
              ram_ready     = 1'b1;
              ram_read_data = '0;
            end else begin
              cur    = ram_q.pop_front();
              active = 1'b1;
              cnt    = cur.lat;
            end
          end
          if (active) begin
            chk("ram_addr", ram_addr, cur.addr);
            chk("ram_sel", {28'd0, ram_sel}, {28'd0, cur.sel});
            chk("ram_write_en", {31'd0, ram_write_en}, {31'd0, cur.we});
            chk("ram_write_data", ram_write_data, cur.wdata);
            cnt--;
            if (cnt <= 0) begin
              ram_ready     = 1'b1;
              ram_read_data = cur.rdata;
              active        = 1'b0;
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    mem_read_flag_in = 0; mem_write_flag_in = 0; mem_sign_flag_in = 0;
    mem_sel_in = 4'hF; mem_write_data_in = 0; result_in = 0;
    reg_write_en_in = 0; reg_write_addr_in = 0; current_pc_addr_in = 0;
    ram_ready = 0; ram_read_data = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ram_en", {31'd0, ram_en}, 32'd0);
    chk("reset_ram_write_en", {31'd0, ram_write_en}, 32'd0);
    chk("reset_ram_addr", ram_addr, 32'd0);
    chk("reset_ram_sel", {28'd0, ram_sel}, 32'd0);
    chk("reset_ram_write_data", ram_write_data, 32'd0);
    chk("reset_stall", {31'd0, stall_request}, 32'd0);
    rst = 1'b0;
    ram_auto = 1'b1;
    @(posedge clk);
    #1;

    // Non-memory pass-through
    exp_ret(32'h55, 1, 5'd3, 32'h1000, 0, 0);
    issue(0, 0, 0, 4'hF, 32'h0, 32'h55, 1, 5'd3, 32'h1000);
    // Word load, ready two cycles after ram_en
    exp_ram(32'h100, 4'b1111, 0, 32'h0, 32'hDEADBEEF, 2);
    exp_ret(32'hDEADBEEF, 1, 5'd5, 32'h1004, 3, 0);
    issue(1, 0, 0, 4'b1111, 32'h0, 32'h100, 1, 5'd5, 32'h1004);
    // Signed byte load, top lane
    exp_ram(32'h100, 4'b1000, 0, 32'h0, 32'h80FF0000, 1);
    exp_ret(32'hFFFFFF80, 1, 5'd6, 32'h1008, 2, 0);
    issue(1, 0, 1, 4'b0001, 32'h0, 32'h103, 1, 5'd6, 32'h1008);
    // Same byte, zero-extended
    exp_ram(32'h100, 4'b1000, 0, 32'h0, 32'h80FF0000, 1);
    exp_ret(32'h00000080, 1, 5'd6, 32'h100C, 2, 0);
    issue(1, 0, 0, 4'b0001, 32'h0, 32'h103, 1, 5'd6, 32'h100C);
    // Halfword store in upper half
    exp_ram(32'h200, 4'b1100, 1, 32'h12340000, 32'h0BADF00D, 3);
    exp_ret(32'h202, 0, 5'd0, 32'h1010, 4, 0);
    issue(0, 1, 0, 4'b0011, 32'h1234, 32'h202, 0, 5'd0, 32'h1010);
    // Signed halfword load, negative
    exp_ram(32'h200, 4'b1100, 0, 32'h0, 32'h80010000, 1);
    exp_ret(32'hFFFF8001, 1, 5'd8, 32'h1014, 2, 0);
    issue(1, 0, 1, 4'b0011, 32'h0, 32'h202, 1, 5'd8, 32'h1014);
    // Signed byte load, positive value in lane 1
    exp_ram(32'h100, 4'b0010, 0, 32'h0, 32'h12345678, 1);
    exp_ret(32'h00000056, 1, 5'd9, 32'h1018, 2, 0);
    issue(1, 0, 1, 4'b0001, 32'h0, 32'h101, 1, 5'd9, 32'h1018);
    // Unsigned halfword load, lane 0, high bit set
    exp_ram(32'h0, 4'b0011, 0, 32'h0, 32'h1234F00D, 2);
    exp_ret(32'h0000F00D, 1, 5'd10, 32'h101C, 3, 0);
    issue(1, 0, 0, 4'b0011, 32'h0, 32'h0, 1, 5'd10, 32'h101C);
    // Read and write both set: treated as a word store
    exp_ram(32'h104, 4'b1111, 1, 32'hCAFEF00D, 32'hFFFFFFFF, 2);
    exp_ret(32'h104, 1, 5'd11, 32'h1020, 3, 0);
    issue(1, 1, 0, 4'b1111, 32'hCAFEF00D, 32'h104, 1, 5'd11, 32'h1020);
    // Byte store into top lane
    exp_ram(32'h0, 4'b1000, 1, 32'hAB000000, 32'h0, 1);
    exp_ret(32'h3, 0, 5'd0, 32'h1024, 2, 0);
    issue(0, 1, 0, 4'b0001, 32'h000000AB, 32'h3, 0, 5'd0, 32'h1024);
`ifdef MEM_MISALIGN_CHECK_EN
    // Misaligned word load is trapped without touching RAM
    exp_ret(32'h101, 0, 5'd7, 32'h1028, 0, 1);
    issue(1, 0, 0, 4'b1111, 32'h0, 32'h101, 1, 5'd7, 32'h1028);
    // Misaligned halfword load is trapped too
    exp_ret(32'h203, 0, 5'd7, 32'h102C, 0, 1);
    issue(1, 0, 0, 4'b0011, 32'h0, 32'h203, 1, 5'd7, 32'h102C);
`else
    // Misaligned word store proceeds with truncated strobes
    exp_ram(32'h100, 4'b1110, 1, 32'h22334400, 32'h0, 1);
    exp_ret(32'h101, 0, 5'd0, 32'h1028, 2, 0);
    issue(0, 1, 0, 4'b1111, 32'h11223344, 32'h101, 0, 5'd0, 32'h1028);
    // Misaligned halfword load keeps only the top lane strobe
    exp_ram(32'h200, 4'b1000, 0, 32'h0, 32'hAB000000, 1);
    exp_ret(32'h000000AB, 1, 5'd7, 32'h102C, 2, 0);
    issue(1, 0, 0, 4'b0011, 32'h0, 32'h203, 1, 5'd7, 32'h102C);
`endif
    mon_en = 1'b0;
    mem_read_flag_in = 0; mem_write_flag_in = 0;

    // Reset in the middle of an access, then a late ready
    ram_auto = 1'b0;
    @(posedge clk);
    #1;
    mem_read_flag_in = 1; mem_sel_in = 4'hF; result_in = 32'h40; reg_write_en_in = 1;
    @(negedge clk);
    chk("idle_memop_stall", {31'd0, stall_request}, 32'd1);
    chk("idle_memop_rwe", {31'd0, reg_write_en_out}, 32'd0);
    @(posedge clk);
    #1;
    chk("access_ram_en", {31'd0, ram_en}, 32'd1);
    chk("access_ram_addr", ram_addr, 32'h40);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_access_ram_en", {31'd0, ram_en}, 32'd0);
    chk("rst_access_ram_addr", ram_addr, 32'd0);
    chk("rst_access_ram_sel", {28'd0, ram_sel}, 32'd0);
    chk("rst_stall_from_inputs", {31'd0, stall_request}, 32'd1);
    rst = 1'b0;
    mem_read_flag_in = 0;
    ram_ready = 1'b1;
    ram_read_data = 32'h12345678;
    @(negedge clk);
    chk("late_ready_stall", {31'd0, stall_request}, 32'd0);
    chk("late_ready_result", result_out, 32'h40);
    @(posedge clk);
    #1;
    chk("late_ready_ram_en", {31'd0, ram_en}, 32'd0);
    chk("late_ready_no_stall", {31'd0, stall_request}, 32'd0);
    ram_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("scoreboard_ret_drained", ret_q.size(), 32'd0);
    chk("scoreboard_ram_drained", ram_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
